spi_slave_rx: RTL
=================

Name: spi_slave_rx

Overview:
- Receive end of the team's 12-bit SPI link. Deserialises `mosi` into parallel words under `cs`/`sclk` supplied by the SPI master.
- Runs entirely on the fast system clock (100 MHz). `sclk`, `cs` and `mosi` are asynchronous inputs: they are synchronised and edge-detected internally.
- Delivers each completed word through a valid/ready interface and flags framing and overrun errors.

Parameters:
- WIDTH, 12, bits per frame; data arrives LSB first.
- SYNC_STAGES, 2, flip-flop stages in the synchroniser on each of `sclk`, `cs` and `mosi` (minimum 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  serial clock from the master; idle low.
- cs  input  1  chip select from the master, active low.
- mosi  input  1  serial data from the master; changes on the `sclk` rising edge.
- dout  output  WIDTH  received word; stable while `dout_valid` is high.
- dout_valid  output  1  word available.
- dout_ready  input  1  consumer accepts the word.
- frame_err  output  1  1-clk pulse: `cs` rose before WIDTH bits were received.
- overrun  output  1  1-clk pulse: a word completed while `dout_valid` was still high.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (on `clk` edge while `rst`=1):
  - outputs: `dout`=0, `dout_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0;
  - state: state=IDLE, bit counter=0, shift register=0;
  - synchronisers load their idle values: `sclk`=0, `cs`=1, `mosi`=0.
  - Reset mid-frame discards the partial word. The remainder of that frame is ignored until `cs` is seen high.
- Synchronisation and edge detection:
  - A falling edge (`fall`) = synchronised `sclk` was 1 last cycle and is 0 now.
  - `cs` and `mosi` use the same synchroniser depth as `sclk`, so all three are aligned.
  - All decisions use the synchronised signals only.
- Sampling rule: `mosi` is sampled on `fall`, i.e. mid-bit. The master drives bit0 one `sclk` period after asserting `cs`, so the first `fall` after `cs` goes low is a lead-in and is discarded.
- FSM:
  - IDLE: when synchronised `cs`=0 → LEAD.
  - LEAD: on `fall` → SHIFT, bit counter=0. If `cs`=1 → IDLE with no error (no data was sent).
  - SHIFT:
    - on `fall`: shift register[counter] ← `mosi`, then counter++.
    - when the WIDTH-th sample is taken → WAIT_CS and deliver the word (see below).
    - if `cs`=1 before WIDTH samples: `frame_err` pulses, the partial word is dropped, → IDLE.
  - WAIT_CS: all further `fall` events are ignored. When `cs`=1 → IDLE.
- Word delivery, on the cycle after the WIDTH-th sample:
  - If `dout_valid`=0: `dout` ← word and `dout_valid` ← 1.
  - If `dout_valid`=1 and `dout_ready`=0 that cycle: the new word is dropped, `dout` keeps the old word, and `overrun` pulses.
  - If `dout_valid`=1 and `dout_ready`=1 that cycle: the handshake and the load happen together. `dout` ← new word, `dout_valid` stays 1, no overrun.
- Handshake:
  - `dout_valid` clears on the cycle after `dout_valid`&`dout_ready`, unless a new load occurs in the same cycle.
  - `dout_ready` has no effect when `dout_valid`=0.
- Latency: `dout_valid` rises SYNC_STAGES+2 `clk` cycles after the physical 12th `sclk` falling edge. This is fixed and must be checked exactly.
- Back-to-back frames: after `cs` is seen high, a new `cs` low is accepted from the next cycle.
- `cs` held permanently low: after one word the block stays in WAIT_CS and captures nothing more.

Test Plan:
- Single frame 12'hA5C, sent LSB first at `sclk`=1 MHz, sourced by the team's SPI master → `dout`=12'hA5C, `dout_valid` high at the exact latency, `frame_err`=0, `overrun`=0, `busy` falls after `cs` rises.
- Two frames, 12'h001 then 12'hFFF, with `dout_ready` tied high → two separate valid pulses with `dout`=12'h001 then 12'hFFF; no errors.
- `cs` raised after 5 bits of 12'h3C3 → one `frame_err` pulse, `dout_valid` stays 0, and the next full frame 12'h123 is received correctly.
- `dout_ready` held low across frames 12'h111 and 12'h222 → `overrun` pulses once, `dout` stays 12'h111. Assert `dout_ready` → `dout_valid` clears on the next cycle.
- `rst` asserted after bit 6 of a frame and released with `cs` still low → no word delivered and no `frame_err`. The following frame 12'h5A5 is received correctly.
- `cs` held low with 20 `sclk` periods of data → exactly one word, taken from bits 0–11; remaining edges ignored; `busy` stays high until `cs` rises.

Source files
------------

// File: rtl/spi_slave_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_slave_rx
// Receive end of the 12-bit SPI link. All three SPI inputs are asynchronous to
// clk; they are synchronised through equal-depth chains so that sclk, cs and
// mosi stay mutually aligned, and mosi is sampled on the synchronised sclk
// falling edge (mid-bit). The first falling edge after cs goes low is a
// lead-in and carries no data. Completed words leave through a valid/ready
// port; framing and overrun problems are flagged as single-cycle pulses.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   sclk        serial clock from master (idle low)
//   cs          chip select from master, active low
//   mosi        serial data, LSB first, changes on sclk rising edge
//   dout        received word, stable while dout_valid is high
//   dout_valid  word available
//   dout_ready  consumer accepts the word
//   frame_err   pulse: cs rose before WIDTH bits were received
//   overrun     pulse: a word completed while dout_valid was still high
//   busy        high in every FSM state except IDLE
// -----------------------------------------------------------------------------
module spi_slave_rx #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LEAD    = 2'd1;
  localparam logic [1:0] SHIFT   = 2'd2;
  localparam logic [1:0] WAIT_CS = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  // Tracks how many chain stages hold real (post-reset) samples.
  logic [SYNC_STAGES-1:0] sync_live_r;
  logic                   sclk_prev_r;
  // Set once cs has genuinely been observed high; until then a low cs is
  // assumed to belong to a frame that was interrupted by reset.
  logic                   armed_r;

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] shreg_r;
  logic             word_done_r;

  logic             sclk_s;
  logic             cs_s;
  logic             mosi_s;
  logic             fall_s;

  logic [1:0]       state_next_s;
  logic [CW-1:0]    cnt_next_s;
  logic [WIDTH-1:0] shreg_next_s;
  logic             done_next_s;
  logic             ferr_next_s;

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s   = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
  assign fall_s = sclk_prev_r & ~sclk_s;

  // Input synchronisers and sclk edge history; reset loads the idle levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sync_live_r <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      sync_live_r <= {sync_live_r[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_r <= sclk_s;
    end
  end

  // Next-state logic for the receive FSM, bit counter and shift register.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    shreg_next_s = shreg_r;
    done_next_s  = 1'b0;
    ferr_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!cs_s && armed_r) begin
          state_next_s = LEAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LEAD: begin
        if (cs_s) begin
          state_next_s = IDLE;
        end else if (fall_s) begin
          state_next_s = SHIFT;
          cnt_next_s   = {CW{1'b0}};
          shreg_next_s = {WIDTH{1'b0}};
        end else begin
          state_next_s = LEAD;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          // cs deasserted mid-word: drop the partial word.
          state_next_s = IDLE;
          ferr_next_s  = 1'b1;
          cnt_next_s   = {CW{1'b0}};
          shreg_next_s = {WIDTH{1'b0}};
        end else if (fall_s) begin
          shreg_next_s[cnt_r] = mosi_s;
          if (cnt_r == LAST_BIT) begin
            state_next_s = WAIT_CS;
            cnt_next_s   = {CW{1'b0}};
            done_next_s  = 1'b1;
          end else begin
            cnt_next_s   = cnt_r + CW'(1);
          end
        end else begin
          state_next_s = SHIFT;
        end
      end
      WAIT_CS: begin
        if (cs_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_CS;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // FSM state, shift register, error pulse and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      shreg_r     <= {WIDTH{1'b0}};
      word_done_r <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      shreg_r     <= shreg_next_s;
      word_done_r <= done_next_s;
      frame_err   <= ferr_next_s;
      busy        <= (state_next_s != IDLE);
      armed_r     <= armed_r | (cs_s & sync_live_r[SYNC_STAGES-1]);
    end
  end

  // Output word register and valid/ready handshake; word_done is one cycle
  // after the last sample, so shreg_r already holds the complete word.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= {WIDTH{1'b0}};
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done_r) begin
        if (!dout_valid) begin
          dout       <= shreg_r;
          dout_valid <= 1'b1;
        end else if (!dout_ready) begin
          overrun    <= 1'b1;
        end else begin
          // Handshake and reload in the same cycle: valid stays high.
          dout       <= shreg_r;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end else begin
        dout_valid <= dout_valid;
      end
    end
  end

endmodule
